// File: rtl/maindec_mc.sv
// Multicycle MIPS main decoder: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback and driving datapath strobes and aluop.
module maindec_mc #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regwrite,
    output logic           pcwrite,
    output logic           iord,
    output logic           regdst,
    output logic           memtoreg,
    output logic           alusrca,
    output logic           branch,
    output logic           pcen,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           illegal,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic       branch;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t cur, nxt;
    ctrl_t  ctrl_q;
    logic   known_op;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:          begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            DECODE:         c.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b00; end
            MEMRD:          c.iord = 1'b1;
            MEMWB:          begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:          begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX:        begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            RTYPEWB:        begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            ADDIWB:         c.regwrite = 1'b1;
            BEQEX:          begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            JEX:            begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:        c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                   (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    end

    // Illegal encodings 12..15 fall through the default and recover to FETCH.
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) nxt = MEMADR;
                else if (op == OP_RTYPE)        nxt = RTYPEEX;
                else if (op == OP_BEQ)          nxt = BEQEX;
                else if (op == OP_ADDI)         nxt = ADDIEX;
                else if (op == OP_J)            nxt = JEX;
                else                            nxt = FETCH;
            end
            MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they line up with cur;
    // the reset value is the FETCH decode for the first cycle after release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= FETCH;
            ctrl_q <= decode(FETCH);
        end else if (en) begin
            cur    <= nxt;
            ctrl_q <= decode(nxt);
        end
    end

    // rst_n gates outputs combinationally so writes die at the async edge;
    // en gates only the write strobes, selects keep their state values.
    assign memwrite = rst_n & en & ctrl_q.memwrite;
    assign irwrite  = rst_n & en & ctrl_q.irwrite;
    assign regwrite = rst_n & en & ctrl_q.regwrite;
    assign pcwrite  = rst_n & en & ctrl_q.pcwrite;
    assign pcen     = rst_n & en & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
    assign illegal  = rst_n & en & (cur == DECODE) & ~known_op;
    assign iord     = rst_n & ctrl_q.iord;
    assign regdst   = rst_n & ctrl_q.regdst;
    assign memtoreg = rst_n & ctrl_q.memtoreg;
    assign alusrca  = rst_n & ctrl_q.alusrca;
    assign branch   = rst_n & ctrl_q.branch;
    assign alusrcb  = rst_n ? ctrl_q.alusrcb : 2'b00;
    assign pcsrc    = rst_n ? ctrl_q.pcsrc   : 2'b00;
    assign aluop    = rst_n ? ctrl_q.aluop   : 2'b00;
    assign state    = rst_n ? cur            : 4'd0;

endmodule
